// File: rtl/pwm_pkg.sv
// Shared register map, control-field layout and bus helpers for the PWM peripheral.
package pwm_pkg;

   localparam int unsigned CH_STRIDE = 16;
   localparam int unsigned CTRL_W    = 5;

   localparam logic [3:0] OFF_CTRL    = 4'h0;
   localparam logic [3:0] OFF_DIVISOR = 4'h4;
   localparam logic [3:0] OFF_PERIOD  = 4'h8;
   localparam logic [3:0] OFF_DUTY    = 4'hC;

   localparam int unsigned CTRL_EN      = 0;
   localparam int unsigned CTRL_OE      = 1;
   localparam int unsigned CTRL_POL     = 2;
   localparam int unsigned CTRL_IE      = 3;
   localparam int unsigned CTRL_ONESHOT = 4;

   // Field order puts EN at bit 0 so a cast to 32 bits gives the register image.
   typedef struct packed {
      logic oneshot;
      logic ie;
      logic pol;
      logic oe;
      logic en;
   } ctrl_t;

   // INTR_STATE sits directly after the last channel block.
   function automatic logic [7:0] intr_state_addr(input int unsigned nch);
      return 8'(nch * CH_STRIDE);
   endfunction

   // Replace only the byte lanes selected by be in old.
   function automatic logic [31:0] be_merge(input logic [31:0] old,
                                            input logic [31:0] wdata,
                                            input logic [3:0]  be);
      logic [31:0] r;
      r = old;
      for (int b = 0; b < 4; b++) begin
         if (be[b]) r[8*b +: 8] = wdata[8*b +: 8];
      end
      return r;
   endfunction

endpackage

// File: rtl/pwm_channel.sv
// One PWM channel: registers, prescaler, period counter, staging and output flop.
module pwm_channel
   import pwm_pkg::*;
#(
   parameter int unsigned CW = 16
) (
   input  logic          clk_i,
   input  logic          rst_ni,
   input  logic          ctrl_we,
   input  logic          div_we,
   input  logic          period_we,
   input  logic          duty_we,
   input  logic [3:0]    be,
   input  logic [31:0]   wdata,
   output ctrl_t         ctrl,
   output logic [CW-1:0] divisor,
   output logic [CW-1:0] period,
   output logic [CW-1:0] duty,
   output logic          pwm,
   output logic          wrap_c
);

   logic [CW-1:0] presc;
   logic [CW-1:0] cnt;
   logic [CW-1:0] period_act;
   logic [CW-1:0] duty_act;
   logic          tick_c;
   logic          act_c;

   // Prescaler terminal count, period end and raw output level.
   always_comb begin
      tick_c = ctrl.en && (presc == divisor);
      wrap_c = tick_c && (cnt == period_act);
      act_c  = ctrl.en && (cnt < duty_act);
   end

   // CTRL: a bus write takes priority over the one-shot self-clear of EN.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         ctrl <= '0;
      end else if (ctrl_we && be[0]) begin
         ctrl <= '{oneshot: wdata[CTRL_ONESHOT], ie: wdata[CTRL_IE],
                   pol: wdata[CTRL_POL], oe: wdata[CTRL_OE], en: wdata[CTRL_EN]};
      end else if (wrap_c && ctrl.oneshot) begin
         ctrl.en <= 1'b0;
      end
   end

   // Byte-enabled DIVISOR and staged PERIOD/DUTY; bits above CW are dropped.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         divisor <= '0;
         period  <= '0;
         duty    <= '0;
      end else begin
         if (div_we)    divisor <= CW'(be_merge(32'(divisor), wdata, be));
         if (period_we) period  <= CW'(be_merge(32'(period), wdata, be));
         if (duty_we)   duty    <= CW'(be_merge(32'(duty), wdata, be));
      end
   end

   // Active copies track staging while idle (covers the EN rise) and reload at period end.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         period_act <= '0;
         duty_act   <= '0;
      end else if (!ctrl.en || wrap_c) begin
         period_act <= period;
         duty_act   <= duty;
      end
   end

   // Prescaler and period counter; both held at zero while disabled.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         presc <= '0;
         cnt   <= '0;
      end else if (!ctrl.en) begin
         presc <= '0;
         cnt   <= '0;
      end else begin
         presc <= tick_c ? '0 : presc + CW'(1);
         if (wrap_c)      cnt <= '0;
         else if (tick_c) cnt <= cnt + CW'(1);
      end
   end

   // Output flop: polarity applied only when the pad is enabled.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) pwm <= 1'b0;
      else         pwm <= ctrl.oe && (act_c ^ ctrl.pol);
   end

endmodule

// File: rtl/pwm_multi.sv
// Multi-channel PWM peripheral: register decode, interrupt state and read mux.
module pwm_multi
   import pwm_pkg::*;
#(
   parameter int unsigned NCH = 2,
   parameter int unsigned CW  = 16
) (
   input  logic           clk_i,
   input  logic           rst_ni,
   input  logic           re_i,
   input  logic           we_i,
   input  logic [7:0]     addr_i,
   input  logic [31:0]    wdata_i,
   input  logic [3:0]     be_i,
   output logic [31:0]    rdata_o,
   output logic [NCH-1:0] pwm_o,
   output logic [NCH-1:0] oe_o,
   output logic           intr_o
);

   localparam logic [7:0] INTR_ADDR = intr_state_addr(NCH);

   ctrl_t          ctrl    [NCH];
   logic [CW-1:0]  divisor [NCH];
   logic [CW-1:0]  period  [NCH];
   logic [CW-1:0]  duty    [NCH];
   logic [NCH-1:0] wrap_c;
   logic [NCH-1:0] ie_c;
   logic [NCH-1:0] w1c_c;
   logic [NCH-1:0] intr_state;
   logic           wr_c;

   assign wr_c = we_i & ~re_i;

   for (genvar c = 0; c < NCH; c++) begin : g_ch
      logic sel_c;
      assign sel_c   = wr_c && (addr_i[7:4] == 4'(c));
      assign oe_o[c] = ctrl[c].oe;
      assign ie_c[c] = ctrl[c].ie;

      pwm_channel #(.CW(CW)) u_ch (
         .clk_i     (clk_i),
         .rst_ni    (rst_ni),
         .ctrl_we   (sel_c && (addr_i[3:0] == OFF_CTRL)),
         .div_we    (sel_c && (addr_i[3:0] == OFF_DIVISOR)),
         .period_we (sel_c && (addr_i[3:0] == OFF_PERIOD)),
         .duty_we   (sel_c && (addr_i[3:0] == OFF_DUTY)),
         .be        (be_i),
         .wdata     (wdata_i),
         .ctrl      (ctrl[c]),
         .divisor   (divisor[c]),
         .period    (period[c]),
         .duty      (duty[c]),
         .pwm       (pwm_o[c]),
         .wrap_c    (wrap_c[c])
      );
   end

   // W1C mask limited to enabled byte lanes.
   always_comb begin
      w1c_c = '0;
      if (wr_c && (addr_i == INTR_ADDR)) w1c_c = NCH'(be_merge('0, wdata_i, be_i));
   end

   // Interrupt state: a period-end set overrides a simultaneous clear.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) intr_state <= '0;
      else         intr_state <= (intr_state & ~w1c_c) | wrap_c;
   end

   assign intr_o = |(intr_state & ie_c);

   // Combinational read mux; unmapped addresses return zero.
   always_comb begin
      rdata_o = '0;
      if (addr_i == INTR_ADDR) rdata_o = 32'(intr_state);
      for (int c = 0; c < NCH; c++) begin
         if (addr_i[7:4] == 4'(c)) begin
            case (addr_i[3:0])
               OFF_CTRL:    rdata_o = 32'(ctrl[c]);
               OFF_DIVISOR: rdata_o = 32'(divisor[c]);
               OFF_PERIOD:  rdata_o = 32'(period[c]);
               OFF_DUTY:    rdata_o = 32'(duty[c]);
               default:     ;
            endcase
         end
      end
   end

endmodule
